alu_mdu: RTL and testbench
==========================

// Module: alu_mdu
// PURPOSE
//  Parametrised-width ALU with an iterative multiply/divide unit; next-gen execute block for the multi-cycle CPU.
//  Single-cycle ops return a registered result one cycle after acceptance; MUL/DIV take WIDTH+2 cycles.
//  Start/busy/done handshake lets the control unit stall the pipeline while a mul/div is in flight.
// PARAMETERS
//  WIDTH  32  datapath width; even, >= 8; SH = clog2(WIDTH) shift-amount bits
// PORTS
//  clk_i     in   1        clock, all state updates on rising edge
//  rst_i     in   1        synchronous reset, active-low
//  start_i   in   1        request; accepted in a cycle where start_i=1 and busy_o=0
//  ctrl_i    in   4        operation code, sampled on acceptance
//  src1_i    in   WIDTH    operand 1 (rs), sampled on acceptance
//  src2_i    in   WIDTH    operand 2 (rt/imm), sampled on acceptance
//  shamt_i   in   SH       shift amount for SLL/SRL/SRA, sampled on acceptance
//  busy_o    out  1        iterative op in progress; new starts ignored
//  done_o    out  1        one-cycle pulse: result_o/hi_o valid from this cycle
//  result_o  out  WIDTH    ALU result / product low half / quotient
//  hi_o      out  WIDTH    product high half / remainder; 0 for single-cycle ops
//  zero_o    out  1        result_o == 0 (combinational from result_o)
// BEHAVIOUR
//  Reset (rst_i=0 at edge): state IDLE, busy_o=0, done_o=0, result_o=0, hi_o=0 (so zero_o=1); aborts any op in flight.
//  Codes: ADD 0000, SUB 0010, AND 0100, OR 0101, SLT 1010 (signed), SLTU 1011, SLL 1101 (src2<<shamt),
//   SLLV 1100 (src2<<src1[SH-1:0]), LUI 1111 (src2<<WIDTH/2), SRL 1110, SRA 0001 (arith, by shamt),
//   MUL 0110 (signed), MULU 0111, DIV 1000 (signed), DIVU 1001. Undefined codes: single-cycle, result 0, hi 0.
//  ADD/SUB wrap modulo 2^WIDTH, no overflow flag. SLT/SLTU give 1 or 0.
//  FSM states IDLE, CALC, FIX. Acceptance in cycle 0:
//   single-cycle op: stay IDLE; result registered at end of cycle 0; done_o=1 in cycle 1; busy_o stays 0.
//   MUL*/DIV*: IDLE->CALC; busy_o=1 cycles 1..WIDTH+1; CALC does one shift-add / restoring-subtract step
//   per cycle for WIDTH cycles on magnitudes; FIX (1 cycle) applies sign correction and loads outputs;
//   done_o=1 in cycle WIDTH+2, state back to IDLE, busy_o=0 in that cycle.
//  A start accepted in the done_o cycle is legal (back-to-back). start_i while busy_o=1 is dropped, no effect.
//  result_o/hi_o hold until the next accepted op completes; intermediate values never appear on outputs.
//  MUL: {hi_o,result_o} = full 2*WIDTH-bit product (signed or unsigned per code).
//  DIV: quotient truncates toward zero; remainder takes sign of dividend.
//  Divide by zero (src2=0): result_o = all-ones, hi_o = src1; same latency as a normal divide.
//  Signed overflow (DIV, src1=MIN, src2=-1): result_o = MIN, hi_o = 0.
//  Reset asserted during CALC/FIX: next cycle IDLE with reset values; no done_o pulse for the aborted op.
// TESTING
//  1. WIDTH=32: ADD 5+7 at cycle 0 -> cycle 1 done_o=1, result_o=12, hi_o=0, zero_o=0, busy_o never 1.
//  2. SUB 9-9 -> result_o=0, zero_o=1; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
//  3. MUL -3*7: busy_o=1 cycles 1..33, done_o=1 cycle 34 only, result_o=0xFFFFFFEB, hi_o=0xFFFFFFFF; MULU 0xFFFFFFFF^2 -> hi 0xFFFFFFFE, lo 0x00000001.
//  4. DIV -7/2 -> result_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 100/0 -> result_o=0xFFFFFFFF, hi_o=100; DIV 0x80000000/-1 -> 0x80000000, hi_o=0.
//  5. Start DIVU 10/3, pulse start_i with ADD during busy -> ignored; done gives 3/1; ADD issued in done cycle completes next cycle.
//  6. Reset at cycle 10 of a MUL -> next cycle busy_o=0, result_o=0, no done_o; repeat 1-4 scaled at WIDTH=16 (MUL done at cycle 18).

Source files
------------

// File: rtl/alu_mdu.sv
// Execute block: single-cycle ALU plus an iterative shift-add multiplier / restoring divider.
// Start/busy/done handshake; outputs hold until the next accepted operation completes.
module alu_mdu #(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned SH = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [SH-1:0]    shamt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             zero_o
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned W2 = 2 * WIDTH;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SRA  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_SLLV = 4'b1100;
   localparam logic [3:0] OP_SLL  = 4'b1101;
   localparam logic [3:0] OP_SRL  = 4'b1110;
   localparam logic [3:0] OP_LUI  = 4'b1111;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state, state_d;
   logic             busy_d, done_d;
   logic [WIDTH-1:0] result_d, hi_d;
   logic [WIDTH-1:0] mcand, mcand_d;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_hi, acc_hi_d;   // partial product high half / running remainder
   logic [WIDTH-1:0] acc_lo, acc_lo_d;   // multiplier bits / dividend shifting into quotient
   logic [CW-1:0]    cnt, cnt_d;
   logic             is_div, is_div_d;
   logic             neg_lo, neg_lo_d;
   logic             neg_hi, neg_hi_d;
   logic             div0, div0_d;

   logic [WIDTH-1:0] alu_res;
   logic             is_mdu, sgn;
   logic [WIDTH:0]   sum, shifted;
   logic             ge;
   logic [WIDTH-1:0] diff;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
      return (s && x[WIDTH-1]) ? -x : x;
   endfunction

   // Single-cycle operations
   always_comb begin
      alu_res = '0;
      case (ctrl_i)
         OP_ADD:  alu_res = src1_i + src2_i;
         OP_SUB:  alu_res = src1_i - src2_i;
         OP_AND:  alu_res = src1_i & src2_i;
         OP_OR:   alu_res = src1_i | src2_i;
         OP_SLT:  alu_res = WIDTH'($signed(src1_i) < $signed(src2_i));
         OP_SLTU: alu_res = WIDTH'(src1_i < src2_i);
         OP_SLL:  alu_res = src2_i << shamt_i;
         OP_SLLV: alu_res = src2_i << src1_i[SH-1:0];
         OP_LUI:  alu_res = src2_i << (WIDTH / 2);
         OP_SRL:  alu_res = src2_i >> shamt_i;
         OP_SRA:  alu_res = $unsigned($signed(src2_i) >>> shamt_i);
         default: alu_res = '0;
      endcase
   end

   assign is_mdu   = (ctrl_i[3:1] == 3'b011) || (ctrl_i[3:1] == 3'b100);
   assign sgn      = ~ctrl_i[0];

   // One iteration step on magnitudes, plus the final sign correction
   assign sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
   assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
   assign ge       = shifted >= {1'b0, mcand};
   assign diff     = shifted[WIDTH-1:0] - mcand;
   assign prod_fix = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
   assign quo_fix  = neg_lo ? -acc_lo : acc_lo;
   assign rem_fix  = neg_hi ? -acc_hi : acc_hi;

   always_comb begin
      state_d  = state;
      busy_d   = busy_o;
      done_d   = 1'b0;
      result_d = result_o;
      hi_d     = hi_o;
      mcand_d  = mcand;
      acc_hi_d = acc_hi;
      acc_lo_d = acc_lo;
      cnt_d    = cnt;
      is_div_d = is_div;
      neg_lo_d = neg_lo;
      neg_hi_d = neg_hi;
      div0_d   = div0;
      case (state)
         IDLE: begin
            if (start_i && !busy_o) begin
               if (is_mdu) begin
                  state_d  = CALC;
                  busy_d   = 1'b1;
                  cnt_d    = '0;
                  acc_hi_d = '0;
                  is_div_d = ctrl_i[3];
                  neg_lo_d = sgn & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                  if (ctrl_i[3]) begin
                     mcand_d  = mag(src2_i, sgn);
                     acc_lo_d = mag(src1_i, sgn);
                     neg_hi_d = sgn & src1_i[WIDTH-1];
                     div0_d   = (src2_i == '0);
                  end else begin
                     mcand_d  = mag(src1_i, sgn);
                     acc_lo_d = mag(src2_i, sgn);
                     neg_hi_d = 1'b0;
                     div0_d   = 1'b0;
                  end
               end else begin
                  result_d = alu_res;
                  hi_d     = '0;
                  done_d   = 1'b1;
               end
            end
         end
         CALC: begin
            if (is_div) begin
               acc_hi_d = ge ? diff : shifted[WIDTH-1:0];
               acc_lo_d = {acc_lo[WIDTH-2:0], ge};
            end else begin
               acc_hi_d = sum[WIDTH:1];
               acc_lo_d = {sum[0], acc_lo[WIDTH-1:1]};
            end
            cnt_d = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            // Divide by zero: remainder sign fix restores src1, quotient forced to all-ones
            if (is_div) begin
               result_d = div0 ? '1 : quo_fix;
               hi_d     = rem_fix;
            end else begin
               result_d = prod_fix[WIDTH-1:0];
               hi_d     = prod_fix[W2-1:WIDTH];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         result_o <= '0;
         hi_o     <= '0;
         mcand    <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div0     <= 1'b0;
      end else begin
         state    <= state_d;
         busy_o   <= busy_d;
         done_o   <= done_d;
         result_o <= result_d;
         hi_o     <= hi_d;
         mcand    <= mcand_d;
         acc_hi   <= acc_hi_d;
         acc_lo   <= acc_lo_d;
         cnt      <= cnt_d;
         is_div   <= is_div_d;
         neg_lo   <= neg_lo_d;
         neg_hi   <= neg_hi_d;
         div0     <= div0_d;
      end
   end

   assign zero_o = (result_o == '0);

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: 32-bit instance checked through a scoreboard, 16-bit instance
// checked sequentially with latency measurement.
module tb_alu_mdu;

   localparam logic [3:0] OP_ADD  = 4'b0000, OP_SRA  = 4'b0001, OP_SUB  = 4'b0010, OP_UND = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100, OP_OR   = 4'b0101, OP_MUL  = 4'b0110, OP_MULU = 4'b0111;
   localparam logic [3:0] OP_DIV  = 4'b1000, OP_DIVU = 4'b1001, OP_SLT  = 4'b1010, OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_SLLV = 4'b1100, OP_SLL  = 4'b1101, OP_SRL  = 4'b1110, OP_LUI  = 4'b1111;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
      logic [31:0] hi;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic        start = 1'b0, busy, done, zero;
   logic [3:0]  ctrl = '0;
   logic [31:0] s1 = '0, s2 = '0, res, hi;
   logic [4:0]  sh = '0;

   logic        start16 = 1'b0, busy16, done16, zero16;
   logic [3:0]  ctrl16 = '0;
   logic [15:0] a16 = '0, b16 = '0, res16, hi16;
   logic [3:0]  sh16 = '0;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t tbl[20];

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(32)) dut32 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl), .src1_i(s1), .src2_i(s2),
      .shamt_i(sh), .busy_o(busy), .done_o(done), .result_o(res), .hi_o(hi), .zero_o(zero));

   alu_mdu #(.WIDTH(16)) dut16 (
      .clk_i(clk), .rst_i(rst), .start_i(start16), .ctrl_i(ctrl16), .src1_i(a16), .src2_i(b16),
      .shamt_i(sh16), .busy_o(busy16), .done_o(done16), .result_o(res16), .hi_o(hi16), .zero_o(zero16));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Scoreboard consumer for the 32-bit instance
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %h, expected no completion", res);
         end else begin
            mon_e = sb.pop_front();
            check("result", res, mon_e.res);
            check("hi", hi, mon_e.hi);
            check("zero", zero, mon_e.res == 32'd0);
         end
      end
   end

   // Called at a negedge; returns at the following negedge with start deasserted
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [31:0] er, input logic [31:0] eh,
                        input bit push);
      exp_t t;
      start = 1'b1; ctrl = c; s1 = a; s2 = b; sh = s;
      if (push) begin
         t.res = er;
         t.hi  = eh;
         sb.push_back(t);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no done after %0d cycles, expected done", budget);
      end
   endtask

   task automatic run16(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic [15:0] er, input logic [15:0] eh,
                        input int elat);
      int lat;
      start16 = 1'b1; ctrl16 = c; a16 = a; b16 = b; sh16 = s;
      @(negedge clk);
      start16 = 1'b0;
      lat = 1;
      while (done16 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("w16_latency", 64'(lat), 64'(elat));
      check("w16_result", res16, er);
      check("w16_hi", hi16, eh);
      check("w16_zero", zero16, er == 16'd0);
      @(negedge clk);
   endtask

   initial begin
      int bad, dcnt, da, db, q, r;
      longint p;
      logic [31:0] ra, rb;
      logic [63:0] pu;

      tbl[0]  = '{OP_ADD,  32'd5,         32'd7,         5'd0,  32'd12,        32'd0};
      tbl[1]  = '{OP_SUB,  32'd9,         32'd9,         5'd0,  32'd0,         32'd0};
      tbl[2]  = '{OP_SLT,  32'hFFFFFFFF,  32'd1,         5'd0,  32'd1,         32'd0};
      tbl[3]  = '{OP_SLTU, 32'hFFFFFFFF,  32'd1,         5'd0,  32'd0,         32'd0};
      tbl[4]  = '{OP_SRA,  32'd0,         32'h80000000,  5'd4,  32'hF8000000,  32'd0};
      tbl[5]  = '{OP_MULU, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd0,  32'h00000001,  32'hFFFFFFFE};
      tbl[6]  = '{OP_DIV,  32'hFFFFFFF9,  32'd2,         5'd0,  32'hFFFFFFFD,  32'hFFFFFFFF};
      tbl[7]  = '{OP_DIVU, 32'd100,       32'd0,         5'd0,  32'hFFFFFFFF,  32'd100};
      tbl[8]  = '{OP_DIV,  32'h80000000,  32'hFFFFFFFF,  5'd0,  32'h80000000,  32'd0};
      tbl[9]  = '{OP_AND,  32'hF0F0F0F0,  32'h0FF00FF0,  5'd0,  32'h00F000F0,  32'd0};
      tbl[10] = '{OP_OR,   32'h00000F00,  32'h000000F0,  5'd0,  32'h00000FF0,  32'd0};
      tbl[11] = '{OP_SLL,  32'd0,         32'd1,         5'd31, 32'h80000000,  32'd0};
      tbl[12] = '{OP_SLLV, 32'd4,         32'd3,         5'd0,  32'h00000030,  32'd0};
      tbl[13] = '{OP_LUI,  32'd0,         32'h00001234,  5'd0,  32'h12340000,  32'd0};
      tbl[14] = '{OP_SRL,  32'd0,         32'h80000000,  5'd4,  32'h08000000,  32'd0};
      tbl[15] = '{OP_UND,  32'd5,         32'd7,         5'd0,  32'd0,         32'd0};
      tbl[16] = '{OP_ADD,  32'hFFFFFFFF,  32'd1,         5'd0,  32'd0,         32'd0};
      tbl[17] = '{OP_DIV,  32'd7,         32'hFFFFFFFE,  5'd0,  32'hFFFFFFFD,  32'd1};
      tbl[18] = '{OP_DIV,  32'hFFFFFFFB,  32'd0,         5'd0,  32'hFFFFFFFF,  32'hFFFFFFFB};
      tbl[19] = '{OP_DIVU, 32'hFFFFFFFF,  32'd2,         5'd0,  32'h7FFFFFFF,  32'd1};

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", res, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_zero", zero, 1'b1);
      check("rst16_zero", zero16, 1'b1);
      rst = 1'b1;
      @(negedge clk);

      // ADD completes one cycle after acceptance without raising busy
      issue(OP_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 32'd0, 1'b1);
      check("add_done_cycle1", done, 1'b1);
      check("add_busy", busy, 1'b0);
      @(negedge clk);

      // MUL busy window and done timing
      issue(OP_MUL, 32'hFFFFFFFD, 32'd7, 5'd0, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b1);
      bad = 0;
      for (int k = 1; k <= 33; k++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad++;
         @(negedge clk);
      end
      check("mul_busy_window", 64'(bad), 64'd0);
      check("mul_done_cycle34", done, 1'b1);
      check("mul_busy_cycle34", busy, 1'b0);
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         issue(tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].res, tbl[i].hi, 1'b1);
         wait_done(40);
      end

      // Random MUL/DIV against a behavioural model
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 2 == 0) rb = rb >> (i * 3);
         case (i % 4)
            0: begin
               da = $signed(ra); db = $signed(rb);
               p = longint'(da) * longint'(db);
               pu = 64'(p);
               issue(OP_MUL, ra, rb, 5'd0, pu[31:0], pu[63:32], 1'b1);
            end
            1: begin
               pu = {32'd0, ra} * {32'd0, rb};
               issue(OP_MULU, ra, rb, 5'd0, pu[31:0], pu[63:32], 1'b1);
            end
            2: begin
               if (rb == 32'd0) rb = 32'd1;
               if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
               da = $signed(ra); db = $signed(rb);
               q = da / db; r = da % db;
               issue(OP_DIV, ra, rb, 5'd0, 32'(q), 32'(r), 1'b1);
            end
            default: begin
               if (rb == 32'd0) rb = 32'd1;
               issue(OP_DIVU, ra, rb, 5'd0, ra / rb, ra % rb, 1'b1);
            end
         endcase
         wait_done(40);
      end

      // Start during busy is dropped; back-to-back start in the done cycle
      @(negedge clk);
      issue(OP_DIVU, 32'd10, 32'd3, 5'd0, 32'd3, 32'd1, 1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1; ctrl = OP_ADD; s1 = 32'd1; s2 = 32'd1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_drop", busy, 1'b1);
      wait_done(40);
      issue(OP_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 32'd0, 1'b1);
      check("b2b_done", done, 1'b1);
      @(negedge clk);

      // Reset in the middle of a MUL aborts it silently
      issue(OP_MUL, 32'd3, 32'd7, 5'd0, 32'd0, 32'd0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_result", res, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_done", done, 1'b0);
      rst = 1'b1;
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
      check("abort_no_done", 64'(dcnt), 64'd0);

      // Scaled checks at WIDTH=16
      run16(OP_ADD,  16'd5,    16'd7,    4'd0, 16'd12,   16'd0,    1);
      run16(OP_SUB,  16'd9,    16'd9,    4'd0, 16'd0,    16'd0,    1);
      run16(OP_SLT,  16'hFFFF, 16'd1,    4'd0, 16'd1,    16'd0,    1);
      run16(OP_SLTU, 16'hFFFF, 16'd1,    4'd0, 16'd0,    16'd0,    1);
      run16(OP_SRA,  16'd0,    16'h8000, 4'd4, 16'hF800, 16'd0,    1);
      run16(OP_LUI,  16'd0,    16'h00AB, 4'd0, 16'hAB00, 16'd0,    1);
      run16(OP_MUL,  16'hFFFD, 16'd7,    4'd0, 16'hFFEB, 16'hFFFF, 18);
      run16(OP_MULU, 16'hFFFF, 16'hFFFF, 4'd0, 16'h0001, 16'hFFFE, 18);
      run16(OP_DIV,  16'hFFF9, 16'd2,    4'd0, 16'hFFFD, 16'hFFFF, 18);
      run16(OP_DIVU, 16'd100,  16'd0,    4'd0, 16'hFFFF, 16'd100,  18);
      run16(OP_DIV,  16'h8000, 16'hFFFF, 4'd0, 16'h8000, 16'd0,    18);

      @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
